sap_slave_regfile: RTL and testbench
====================================

// Module: sap_slave_regfile
// PURPOSE
//  Responder end of the SAP slave interface: answers host-initiated address/write/read transactions on the
//  slave_* port group with a 128-bit-wide register file. Sits inside the accelerator top beside the matcher
//  core. Exports a self-clearing start pulse and configuration registers to the core, and returns core status.
// PARAMETERS
//  BASE_ADDR  64'h0  byte address of register 0; registers are 16 bytes apart
//  NUM_REGS   8      total registers, 3..64; reg0 = CTRL, reg1 = STATUS (read-only), reg2..NUM_REGS-1 = CFG
//  BAD_DATA   128'hDEADBEEF  read data returned for out-of-range reads
// PORTS
//  sap_clk               in   1    sole clock
//  sap_rst               in   1    asynchronous, active-low reset (0 = reset)
//  slave_address         in   64   transaction start byte address, qualified by slave_address_valid
//  slave_transaction_id  in   4    transaction tag, latched with the address
//  slave_address_valid   in   1    host presents a new address
//  slave_address_ack     out  1    1-cycle pulse: address accepted
//  slave_wrreq           in   4    write beat request when != 0
//  slave_wrack           out  1    1-cycle pulse: write beat consumed
//  slave_be              in   16   byte enables for slave_datain; bit i enables byte i
//  slave_datain          in   128  write beat data
//  slave_rdreq           in   4    read beat request when != 0
//  slave_rdack           out  1    1-cycle pulse: slave_dataout valid
//  slave_dataout         out  128  read beat data, valid only while slave_rdack = 1
//  active_tag            out  4    transaction id latched at the last address accept
//  core_start            out  1    1-cycle pulse when 1 is written to CTRL bit 0
//  core_status           in   128  returned on reads of reg1
//  cfg_regs              out  (NUM_REGS-2)*128  CFG contents, reg2 at LSBs
// BEHAVIOUR
//  Reset: all outputs 0, all registers 0, FSM = IDLE; reset asserted mid-transaction aborts it, no ack issued.
//  FSM IDLE -> ACK when slave_address_valid; ACK (address_ack = 1 this cycle, latch addr/id) -> ACTIVE;
//   ACTIVE -> ACK when slave_address_valid again (next transaction); otherwise stays ACTIVE.
//  wrreq/rdreq are ignored in IDLE and ACK (no ack, no side effect).
//  Index = (addr - BASE_ADDR) >> 4; addr[3:0] ignored. Out of range if addr < BASE_ADDR or index >= NUM_REGS.
//  Beat acceptance (ACTIVE only): a request is accepted in cycle N only if neither wrack nor rdack is 1 in
//   cycle N -> max one beat per 2 cycles; host drops or re-presents its request after seeing the ack.
//  Write beat: accepted in N -> register updated and slave_wrack = 1 in N+1; bytes with be = 0 keep their value.
//   CTRL: bit 0 self-clearing, drives core_start = 1 in N+1; CTRL bits 127:1 are plain storage.
//   STATUS writes and out-of-range writes are dropped but still acked.
//  Read beat: accepted in N -> slave_rdack = 1 and slave_dataout = data in N+1; dataout = 0 when rdack = 0.
//   CTRL reads return bit 0 as 0; STATUS returns core_status sampled in N; out of range returns BAD_DATA.
//  wrreq and rdreq both != 0 in the same accept cycle: write served first, read accepted at the next opportunity.
//  Each accepted beat increments the internal index by 1 (burst); the index saturates at NUM_REGS,
//   so all further beats are out of range; there is no wrap.
//  address_valid in ACTIVE while a beat ack is due: the ack is still issued in the next cycle, then ACK follows.
//  Widths: index arithmetic is done on 64 bits before the range check; an address below BASE_ADDR never wraps
//   into range.
// TESTING
//  1 Reset, then addr = BASE+0x20, id = 5; write be = 16'hFFFF, data = 128'h1234 -> address_ack 1 cycle after valid;
//    wrack 1 cycle after req; cfg_regs[127:0] = 128'h1234; active_tag = 5.
//  2 Burst from BASE+0x20: write 3 beats A, B, C with NUM_REGS = 4 -> reg2 = A, reg3 = B, C dropped but acked;
//    read 3 beats from BASE+0x20 -> A, B, BAD_DATA, with rdack 1 cycle after each accepted req.
//  3 Write be = 16'h000F, data = all 1s onto reg2 = 0 -> reg2 = 128'hFFFFFFFF; reading reg1 with
//    core_status = 128'h55 -> 128'h55.
//  4 Write 128'h1 to CTRL -> core_start 1-cycle pulse; CTRL read returns 0. Simultaneous wrreq/rdreq on reg2
//    -> wrack first, rdack 2 cycles later returning the new data.
//  5 Addr = BASE-0x10 read -> BAD_DATA. Requests before any address -> no ack. Drop sap_rst during a burst
//    -> all outputs 0 immediately; FSM IDLE; CFG cleared.

Source files
------------

// File: rtl/sap_slave_regfile.sv
// SAP slave responder: 128-bit register file (CTRL, STATUS, CFG...) behind the address/write/read beat protocol.
// Beat acks and read data arrive one cycle after acceptance; at most one beat is accepted every other cycle.
module sap_slave_regfile #(
  parameter logic [63:0]  BASE_ADDR = 64'h0,
  parameter int           NUM_REGS  = 8,
  parameter logic [127:0] BAD_DATA  = 128'hDEADBEEF
) (
  input  logic                       sap_clk,
  input  logic                       sap_rst,
  input  logic [63:0]                slave_address,
  input  logic [3:0]                 slave_transaction_id,
  input  logic                       slave_address_valid,
  output logic                       slave_address_ack,
  input  logic [3:0]                 slave_wrreq,
  output logic                       slave_wrack,
  input  logic [15:0]                slave_be,
  input  logic [127:0]               slave_datain,
  input  logic [3:0]                 slave_rdreq,
  output logic                       slave_rdack,
  output logic [127:0]               slave_dataout,
  output logic [3:0]                 active_tag,
  output logic                       core_start,
  input  logic [127:0]               core_status,
  output logic [(NUM_REGS-2)*128-1:0] cfg_regs
);

  localparam int IW   = $clog2(NUM_REGS + 1);
  localparam int NCFG = NUM_REGS - 2;

  typedef enum logic [1:0] {IDLE, ACK, ACTIVE} state_t;

  state_t                     state_q, state_d;
  logic [IW-1:0]              idx_q, idx_inc, start_idx;
  logic [63:0]                offset, word_idx;
  logic [127:0]               ctrl_q, rd_data;
  logic [NCFG-1:0][127:0]     cfg_q;
  logic                       beat_ok, wr_acc, rd_acc, addr_take;

  function automatic logic [127:0] byte_merge(input logic [127:0] old,
                                              input logic [127:0] din,
                                              input logic [15:0]  be);
    logic [127:0] r;
    r = old;
    for (int b = 0; b < 16; b++)
      if (be[b]) r[8*b +: 8] = din[8*b +: 8];
    return r;
  endfunction

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (slave_address_valid) state_d = ACK;
      ACK:     state_d = ACTIVE;
      ACTIVE:  if (slave_address_valid) state_d = ACK;
      default: state_d = IDLE;
    endcase
  end

  assign slave_address_ack = (state_q == ACK);
  assign addr_take         = (state_d == ACK) && (state_q != ACK);

  // Anything below the base or past the last register parks on the saturated index.
  always_comb begin
    offset   = slave_address - BASE_ADDR;
    word_idx = offset >> 4;
    if (slave_address < BASE_ADDR || word_idx >= 64'(NUM_REGS))
      start_idx = IW'(NUM_REGS);
    else
      start_idx = word_idx[IW-1:0];
  end

  assign idx_inc = (idx_q == IW'(NUM_REGS)) ? idx_q : idx_q + IW'(1);
  assign beat_ok = (state_q == ACTIVE) && !slave_address_valid && !slave_wrack && !slave_rdack;
  assign wr_acc  = beat_ok && (slave_wrreq != 4'd0);
  assign rd_acc  = beat_ok && (slave_wrreq == 4'd0) && (slave_rdreq != 4'd0);

  always_comb begin
    rd_data = BAD_DATA;
    if (idx_q == IW'(0))      rd_data = ctrl_q;
    else if (idx_q == IW'(1)) rd_data = core_status;
    for (int i = 0; i < NCFG; i++)
      if (idx_q == IW'(i + 2)) rd_data = cfg_q[i];
  end

  always_ff @(posedge sap_clk or negedge sap_rst) begin
    if (!sap_rst) begin
      state_q       <= IDLE;
      idx_q         <= '0;
      active_tag    <= '0;
      ctrl_q        <= '0;
      cfg_q         <= '0;
      slave_wrack   <= 1'b0;
      slave_rdack   <= 1'b0;
      slave_dataout <= '0;
      core_start    <= 1'b0;
    end else begin
      state_q       <= state_d;
      slave_wrack   <= wr_acc;
      slave_rdack   <= rd_acc;
      slave_dataout <= rd_acc ? rd_data : 128'd0;
      core_start    <= 1'b0;
      if (addr_take) begin
        idx_q      <= start_idx;
        active_tag <= slave_transaction_id;
      end
      if (wr_acc) begin
        // CTRL bit 0 is never stored: it only fires the start pulse.
        if (idx_q == IW'(0)) begin
          ctrl_q     <= byte_merge(ctrl_q, slave_datain, slave_be) & ~128'h1;
          core_start <= slave_be[0] & slave_datain[0];
        end
        for (int i = 0; i < NCFG; i++)
          if (idx_q == IW'(i + 2)) cfg_q[i] <= byte_merge(cfg_q[i], slave_datain, slave_be);
        // A read queued alongside this write belongs to the same beat, so the index holds until it is served.
        if (slave_rdreq == 4'd0) idx_q <= idx_inc;
      end
      if (rd_acc) idx_q <= idx_inc;
    end
  end

  assign cfg_regs = cfg_q;

endmodule

// File: tb/tb_sap_slave_regfile.sv
// Randomized bench for sap_slave_regfile against a register-array reference model.
module tb_sap_slave_regfile;

  localparam logic [63:0]  BASE = 64'h1000;
  localparam int           NR   = 4;
  localparam logic [127:0] BAD  = 128'hDEADBEEF;

  logic                  clk;
  logic                  rst_n;
  logic [63:0]           slave_address;
  logic [3:0]            slave_transaction_id;
  logic                  slave_address_valid;
  logic                  slave_address_ack;
  logic [3:0]            slave_wrreq;
  logic                  slave_wrack;
  logic [15:0]           slave_be;
  logic [127:0]          slave_datain;
  logic [3:0]            slave_rdreq;
  logic                  slave_rdack;
  logic [127:0]          slave_dataout;
  logic [3:0]            active_tag;
  logic                  core_start;
  logic [127:0]          core_status;
  logic [(NR-2)*128-1:0] cfg_regs;

  int checks = 0;
  int errors = 0;

  logic [127:0] mreg [NR];
  int           midx;

  sap_slave_regfile #(.BASE_ADDR(BASE), .NUM_REGS(NR), .BAD_DATA(BAD)) dut (
    .sap_clk(clk), .sap_rst(rst_n),
    .slave_address(slave_address), .slave_transaction_id(slave_transaction_id),
    .slave_address_valid(slave_address_valid), .slave_address_ack(slave_address_ack),
    .slave_wrreq(slave_wrreq), .slave_wrack(slave_wrack), .slave_be(slave_be),
    .slave_datain(slave_datain), .slave_rdreq(slave_rdreq), .slave_rdack(slave_rdack),
    .slave_dataout(slave_dataout), .active_tag(active_tag), .core_start(core_start),
    .core_status(core_status), .cfg_regs(cfg_regs)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic int calc_idx(input logic [63:0] a);
    logic [63:0] w;
    if (a < BASE) return NR;
    w = (a - BASE) / 16;
    if (w >= 64'(NR)) return NR;
    return int'(w);
  endfunction

  function automatic logic [127:0] mread(input logic [127:0] st);
    if (midx == 0) return mreg[0];
    if (midx == 1) return st;
    if (midx < NR) return mreg[midx];
    return BAD;
  endfunction

  task automatic mwrite(input logic [15:0] be, input logic [127:0] d);
    logic [127:0] v;
    if (midx == 1 || midx >= NR) return;
    v = mreg[midx];
    for (int b = 0; b < 16; b++)
      if (be[b]) v[8*b +: 8] = d[8*b +: 8];
    if (midx == 0) v[0] = 1'b0;
    mreg[midx] = v;
  endtask

  task automatic check_cfg();
    for (int i = 2; i < NR; i++)
      chk($sformatf("cfg%0d", i), cfg_regs[(i-2)*128 +: 128], mreg[i]);
  endtask

  task automatic set_addr(input logic [63:0] a, input logic [3:0] id);
    slave_address = a;
    slave_transaction_id = id;
    slave_address_valid = 1'b1;
    tick();
    chk("addr_ack", slave_address_ack, 1);
    slave_address_valid = 1'b0;
    tick();
    chk("addr_ack_clr", slave_address_ack, 0);
    chk("active_tag", active_tag, id);
    midx = calc_idx(a);
  endtask

  task automatic do_wr(input logic [15:0] be, input logic [127:0] d);
    logic exp_start;
    exp_start = (midx == 0) && be[0] && d[0];
    slave_wrreq = 4'($urandom_range(1, 15));
    slave_be = be;
    slave_datain = d;
    tick();
    chk("wrack", slave_wrack, 1);
    chk("wr_no_rdack", slave_rdack, 0);
    chk("core_start", core_start, exp_start);
    slave_wrreq = 4'd0;
    mwrite(be, d);
    if (midx < NR) midx++;
    check_cfg();
    tick();
    chk("wrack_clr", slave_wrack, 0);
    chk("core_start_clr", core_start, 0);
  endtask

  task automatic do_rd(input logic [127:0] st);
    logic [127:0] exp;
    core_status = st;
    exp = mread(st);
    slave_rdreq = 4'($urandom_range(1, 15));
    tick();
    chk("rdack", slave_rdack, 1);
    chk("rd_no_wrack", slave_wrack, 0);
    chk("rdata", slave_dataout, exp);
    slave_rdreq = 4'd0;
    if (midx < NR) midx++;
    tick();
    chk("rdack_clr", slave_rdack, 0);
    chk("rdata_idle", slave_dataout, 0);
  endtask

  task automatic no_ack_idle(input string tag);
    slave_wrreq = 4'd1;
    slave_rdreq = 4'd1;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk({tag, "_wrack"}, slave_wrack, 0);
      chk({tag, "_rdack"}, slave_rdack, 0);
    end
    slave_wrreq = 4'd0;
    slave_rdreq = 4'd0;
  endtask

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  initial begin
    logic [127:0] a_dat, b_dat, c_dat, d;
    logic [63:0]  addr;
    int           kind, nbeats;

    rst_n = 1'b0;
    slave_address = '0;
    slave_transaction_id = '0;
    slave_address_valid = 1'b0;
    slave_wrreq = '0;
    slave_be = '0;
    slave_datain = '0;
    slave_rdreq = '0;
    core_status = '0;
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    midx = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_addr_ack", slave_address_ack, 0);
    chk("rst_wrack", slave_wrack, 0);
    chk("rst_rdack", slave_rdack, 0);
    chk("rst_dataout", slave_dataout, 0);
    chk("rst_tag", active_tag, 0);
    chk("rst_start", core_start, 0);
    check_cfg();
    rst_n = 1'b1;
    tick();
    no_ack_idle("pre_addr");

    // basic write, then a burst overrunning the last register
    set_addr(BASE + 64'h20, 4'd5);
    do_wr(16'hFFFF, 128'h1234);
    a_dat = rnd128(); b_dat = rnd128(); c_dat = rnd128();
    set_addr(BASE + 64'h20, 4'd3);
    do_wr(16'hFFFF, a_dat);
    do_wr(16'hFFFF, b_dat);
    do_wr(16'hFFFF, c_dat);
    set_addr(BASE + 64'h27, 4'd3);
    do_rd(rnd128());
    do_rd(rnd128());
    do_rd(rnd128());

    // partial byte enables, status read
    set_addr(BASE + 64'h20, 4'd2);
    do_wr(16'hFFFF, 128'h0);
    set_addr(BASE + 64'h20, 4'd2);
    do_wr(16'h000F, {128{1'b1}});
    set_addr(BASE + 64'h10, 4'd7);
    do_rd(128'h55);

    // start pulse and CTRL readback
    set_addr(BASE, 4'd8);
    do_wr(16'hFFFF, 128'h1);
    set_addr(BASE, 4'd8);
    do_rd(rnd128());

    // simultaneous write and read on one beat
    set_addr(BASE + 64'h20, 4'd9);
    d = rnd128();
    slave_be = 16'hFFFF;
    slave_datain = d;
    slave_wrreq = 4'd1;
    slave_rdreq = 4'd2;
    tick();
    chk("sim_wrack", slave_wrack, 1);
    chk("sim_rdack_early", slave_rdack, 0);
    slave_wrreq = 4'd0;
    mwrite(16'hFFFF, d);
    tick();
    chk("sim_gap_rdack", slave_rdack, 0);
    tick();
    chk("sim_rdack", slave_rdack, 1);
    chk("sim_rdata", slave_dataout, mread(128'h0));
    slave_rdreq = 4'd0;
    midx++;
    tick();

    // below-base and far out-of-range addresses
    set_addr(BASE - 64'h10, 4'd4);
    do_rd(rnd128());
    set_addr(64'hFFFF_FFFF_FFFF_FFF0, 4'd4);
    do_wr(16'hFFFF, rnd128());

    for (int t = 0; t < 40; t++) begin
      kind = $urandom_range(0, 7);
      if (kind < 6)       addr = BASE + 64'(kind * 16) + 64'($urandom_range(0, 15));
      else if (kind == 6) addr = BASE - 64'(16 * $urandom_range(1, 4));
      else                addr = 64'hFFFF_FFFF_FFFF_FF00 | 64'($urandom_range(0, 255));
      set_addr(addr, 4'($urandom_range(0, 15)));
      nbeats = $urandom_range(1, 5);
      for (int j = 0; j < nbeats; j++) begin
        if ($urandom_range(0, 1) == 1) do_wr(16'($urandom), rnd128());
        else                           do_rd(rnd128());
      end
    end

    // reset in the middle of a burst
    set_addr(BASE + 64'h20, 4'd6);
    slave_be = 16'hFFFF;
    slave_datain = rnd128() | 128'h1;
    slave_wrreq = 4'd1;
    tick();
    chk("mid_wrack", slave_wrack, 1);
    rst_n = 1'b0;
    #1;
    slave_wrreq = 4'd0;
    for (int i = 0; i < NR; i++) mreg[i] = '0;
    chk("arst_wrack", slave_wrack, 0);
    chk("arst_rdack", slave_rdack, 0);
    chk("arst_addr_ack", slave_address_ack, 0);
    chk("arst_dataout", slave_dataout, 0);
    chk("arst_tag", active_tag, 0);
    chk("arst_start", core_start, 0);
    check_cfg();
    tick();
    rst_n = 1'b1;
    no_ack_idle("post_rst");
    set_addr(BASE + 64'h20, 4'd1);
    do_rd(rnd128());

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
